// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS constants and fetch-stage types
// Purpose: opcode constants, reset/bubble words and the redirect-source enum
//          used by the IF stage and its PC register.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [31:0] NOP_INST   = 32'h0000_0004;
    localparam logic [31:0] RESET_PC   = 32'h0000_0000;
    localparam logic [31:0] WORD_BYTES = 32'd4;
    localparam int          CNT_W      = 16;

    // Which ID-stage redirect won this cycle, highest priority first.
    typedef enum logic [1:0] {
        REDIR_NONE   = 2'd0,
        REDIR_JR     = 2'd1,
        REDIR_JUMP   = 2'd2,
        REDIR_BRANCH = 2'd3
    } redir_e;

endpackage

// File: rtl/pc_reg.sv
// rtl/pc_reg.sv - program counter register with enable
// Purpose: 32-bit PC storage, loads d_i when en_i is high, async active-low reset.
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset (loads RESET_PC)
//   en_i   in   load enable (low while the pipeline is stalled)
//   d_i    in   next PC
//   q_o    out  current PC
module pc_reg #(
    parameter logic [31:0] RESET_PC = mips_pkg::RESET_PC
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en_i,
    input  logic [31:0] d_i,
    output logic [31:0] q_o
);
    import mips_pkg::*;

    logic [31:0] pc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else if (en_i) begin
            pc_q <= d_i;
        end
    end

    assign q_o = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - MIPS IF stage: PC, next-PC select and IF/ID register
// Purpose: drives the instruction memory address, captures the fetched word and
//          PC+4 into IF/ID, applies stalls and squashes the wrong-path slot on
//          jr/j/jal/branch redirects.
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   imem_addr/imem_data byte address out / instruction word in (combinational memory)
//   stall               hold PC, IF/ID and counter
//   branch_taken/target taken beq/bne and its byte target
//   jump/jump_index     j/jal and instr[25:0]
//   jr/jr_target        jr and its register value
//   ifid_pc4/inst/valid IF/ID pipeline register
//   fetch_count         number of valid instructions handed to ID (wraps)
module fetch_stage #(
    parameter logic [31:0] RESET_PC = mips_pkg::RESET_PC,
    parameter logic [31:0] NOP_INST = mips_pkg::NOP_INST,
    parameter int          CNT_W    = mips_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    output logic [31:0]      imem_addr,
    input  logic [31:0]      imem_data,
    input  logic             stall,
    input  logic             branch_taken,
    input  logic [31:0]      branch_target,
    input  logic             jump,
    input  logic [25:0]      jump_index,
    input  logic             jr,
    input  logic [31:0]      jr_target,
    output logic [31:0]      ifid_pc4,
    output logic [31:0]      ifid_inst,
    output logic             ifid_valid,
    output logic [CNT_W-1:0] fetch_count
);
    import mips_pkg::*;

    logic [31:0]      pc_q;
    logic [31:0]      pc_d;
    logic [31:0]      pc4;
    redir_e           redir;
    logic [31:0]      ifid_pc4_q;
    logic [31:0]      ifid_inst_q;
    logic             ifid_valid_q;
    logic [CNT_W-1:0] fetch_count_q;

    assign imem_addr = pc_q;
    assign pc4       = pc_q + WORD_BYTES;

    always_comb begin
        redir = REDIR_NONE;
        if (jr) begin
            redir = REDIR_JR;
        end else if (jump) begin
            redir = REDIR_JUMP;
        end else if (branch_taken) begin
            redir = REDIR_BRANCH;
        end
    end

    // The jump region comes from the PC+4 of the j/jal sitting in ID, not from pc.
    always_comb begin
        pc_d = pc4;
        case (redir)
            REDIR_JR:     pc_d = {jr_target[31:2], 2'b00};
            REDIR_JUMP:   pc_d = {ifid_pc4_q[31:28], jump_index, 2'b00};
            REDIR_BRANCH: pc_d = {branch_target[31:2], 2'b00};
            default:      pc_d = pc4;
        endcase
    end

    pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk   (clk),
        .rst_n (rst),
        .en_i  (~stall),
        .d_i   (pc_d),
        .q_o   (pc_q)
    );

    // PC and IF/ID share the same enable and reset, so they always move as a pair.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ifid_pc4_q    <= 32'd0;
            ifid_inst_q   <= NOP_INST;
            ifid_valid_q  <= 1'b0;
            fetch_count_q <= '0;
        end else if (!stall) begin
            ifid_pc4_q <= pc4;
            if (redir != REDIR_NONE) begin
                // Squash the wrong-path word fetched this cycle.
                ifid_inst_q  <= NOP_INST;
                ifid_valid_q <= 1'b0;
            end else begin
                ifid_inst_q   <= imem_data;
                ifid_valid_q  <= 1'b1;
                fetch_count_q <= fetch_count_q + CNT_W'(1);
            end
        end
    end

    assign ifid_pc4    = ifid_pc4_q;
    assign ifid_inst   = ifid_inst_q;
    assign ifid_valid  = ifid_valid_q;
    assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - self-checking bench for fetch_stage
module tb_fetch_stage;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = 32'd0;
    logic        jump = 1'b0;
    logic [25:0] jump_index = 26'd0;
    logic        jr = 1'b0;
    logic [31:0] jr_target = 32'd0;
    logic [31:0] ifid_pc4;
    logic [31:0] ifid_inst;
    logic        ifid_valid;
    logic [15:0] fetch_count;

    fetch_stage dut (
        .clk           (clk),
        .rst           (rst),
        .imem_addr     (imem_addr),
        .imem_data     (imem_data),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_index    (jump_index),
        .jr            (jr),
        .jr_target     (jr_target),
        .ifid_pc4      (ifid_pc4),
        .ifid_inst     (ifid_inst),
        .ifid_valid    (ifid_valid),
        .fetch_count   (fetch_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9bdf;
    endfunction

    assign imem_data = mem_word(imem_addr);

    int errors = 0;
    int checks = 0;

    logic [31:0] m_pc;
    logic [31:0] m_pc4;
    logic [31:0] m_inst;
    logic        m_valid;
    logic [15:0] m_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc    = 32'h0;
        m_pc4   = 32'h0;
        m_inst  = 32'h4;
        m_valid = 1'b0;
        m_cnt   = 16'd0;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".addr"},  imem_addr, m_pc);
        check({tag, ".pc4"},   ifid_pc4, m_pc4);
        check({tag, ".inst"},  ifid_inst, m_inst);
        check({tag, ".valid"}, {31'd0, ifid_valid}, {31'd0, m_valid});
        check({tag, ".count"}, {16'd0, fetch_count}, {16'd0, m_cnt});
    endtask

    // One clock edge of the reference: plain rules for the IF stage.
    task automatic step(input string tag);
        logic [31:0] seq;
        logic [31:0] target;
        seq = m_pc + 32'd4;
        if (!stall) begin
            if (jr || jump || branch_taken) begin
                if (jr)        target = jr_target & 32'hFFFF_FFFC;
                else if (jump) target = {m_pc4[31:28], jump_index, 2'b00};
                else           target = branch_target & 32'hFFFF_FFFC;
                m_inst  = 32'h4;
                m_valid = 1'b0;
            end else begin
                target  = seq;
                m_inst  = mem_word(m_pc);
                m_valid = 1'b1;
                m_cnt   = m_cnt + 16'd1;
            end
            m_pc4 = seq;
            m_pc  = target;
        end
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic clear_inputs();
        stall = 0; branch_taken = 0; jump = 0; jr = 0;
    endtask

    task automatic async_reset(input string tag);
        rst = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all("reset");
        rst = 1'b1;

        repeat (4) step("seq");
        check("seq.addr16", imem_addr, 32'd16);
        check("seq.count4", {16'd0, fetch_count}, 32'd4);

        async_reset("rst1");
        repeat (2) step("to8");
        stall = 1;
        repeat (2) step("stall");
        check("stall.addr8", imem_addr, 32'd8);
        stall = 0;
        step("resume");
        check("resume.addr12", imem_addr, 32'd12);

        branch_taken = 1; branch_target = 32'h20;
        step("branch");
        check("branch.addr", imem_addr, 32'h20);
        clear_inputs();

        jr = 1; jr_target = 32'h1000_0004;
        step("jr_hi");
        clear_inputs();
        step("seq_hi");
        check("pc4_hi", ifid_pc4, 32'h1000_0008);
        jump = 1; jump_index = 26'h10; branch_taken = 1; branch_target = 32'h44;
        step("jump_prio");
        check("jump.addr", imem_addr, 32'h1000_0040);
        jr = 1; jr_target = 32'h203;
        step("jr_prio");
        check("jr.addr", imem_addr, 32'h200);
        clear_inputs();

        stall = 1; branch_taken = 1; branch_target = 32'h80;
        step("stall_br");
        check("stall_br.addr", imem_addr, 32'h200);
        clear_inputs();
        step("post_stall");
        async_reset("rst_mid");

        jr = 1; jr_target = 32'hFFFF_FFFF;
        step("to_top");
        check("top.addr", imem_addr, 32'hFFFF_FFFC);
        clear_inputs();
        step("wrap");
        check("wrap.addr", imem_addr, 32'h0);
        check("wrap.pc4", ifid_pc4, 32'h0);

        for (int i = 0; i < 400; i++) begin
            stall         = ($urandom_range(0, 3) == 0);
            jr            = ($urandom_range(0, 7) == 0);
            jump          = ($urandom_range(0, 6) == 0);
            branch_taken  = ($urandom_range(0, 5) == 0);
            jr_target     = $urandom;
            branch_target = $urandom;
            jump_index    = 26'($urandom);
            if ($urandom_range(0, 99) == 0) begin
                async_reset("rnd_rst");
            end else begin
                step("rnd");
            end
        end
        clear_inputs();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
